// File: rtl/hist_readout.sv
// Histogram frame readout: streams a header, NWORDS 32-bit words MSB first and an
// XOR checksum over a valid/ready byte port, then optionally clears the histogram.
module hist_readout #(
  parameter int NWORDS   = 66,
  parameter int CLR_HOLD = 70
) (
  input  logic        clkin,
  input  logic        resetn,
  input  logic        start,
  input  logic        clear_after,
  output logic [6:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        resethist,
  output logic        busy,
  output logic        done
);

  localparam int          HW   = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
  localparam logic [6:0]  LAST = 7'(NWORDS - 1);
  localparam logic [7:0]  HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_LATCH, S_SEND, S_CSUM, S_CLR, S_HOLD
  } state_t;

  state_t        state_q;
  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [6:0]    widx_q;
  logic [1:0]    bidx_q;
  logic [31:0]   shift_q;
  logic [7:0]    csum_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          clr_q;
  logic          resethist_q;
  logic          busy_q;
  logic          done_q;
  logic [HW-1:0] hold_q;
  logic          xfer;

  // Assert asynchronously, release two edges later so nothing advances on the release edge.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];
  assign xfer  = tx_valid_q & tx_ready;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      widx_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      csum_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      clr_q       <= 1'b0;
      resethist_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hold_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      resethist_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_HDR;
            busy_q     <= 1'b1;
            clr_q      <= clear_after;
            widx_q     <= '0;
            bidx_q     <= '0;
            csum_q     <= '0;
            tx_data_q  <= HDR_BYTE;
            tx_valid_q <= 1'b1;
          end
        end
        S_HDR: begin
          if (xfer) begin
            state_q    <= S_FETCH;
            tx_valid_q <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          shift_q    <= rd_data;
          tx_data_q  <= rd_data[31:24];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            shift_q <= {shift_q[23:0], 8'h00};
            csum_q  <= csum_q ^ shift_q[31:24];
            bidx_q  <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              if (widx_q == LAST) begin
                state_q   <= S_CSUM;
                tx_data_q <= csum_q ^ shift_q[31:24];
              end else begin
                state_q    <= S_FETCH;
                widx_q     <= widx_q + 7'd1;
                tx_valid_q <= 1'b0;
              end
            end else begin
              tx_data_q <= shift_q[23:16];
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            tx_valid_q <= 1'b0;
            if (clr_q) begin
              state_q     <= S_CLR;
              resethist_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_CLR: begin
          hold_q  <= HW'(CLR_HOLD - 1);
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr   = widx_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign resethist = resethist_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/hist_readout.md
HIST_READOUT -- requirements
Module: hist_readout

Interface
REQ-001 Parameter NWORDS, default 66, number of 32-bit histogram words per frame (2 channel counts + 64 inter-photon-interval bins).
REQ-002 Parameter CLR_HOLD, default 70, clkin cycles busy stays high after resethist pulse (covers the counter's 64-bin clear sweep).
REQ-003 clkin  in  1  sole clock, all logic on rising edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to dump one frame; ignored while busy=1.
REQ-006 clear_after  in  1  sampled with accepted start; 1 = pulse resethist after the frame.
REQ-007 rd_addr  out  7  word address: 0..1 channel counts, 2..65 interval bins 0..63.
REQ-008 rd_data  in  32  word at rd_addr, valid exactly one cycle after rd_addr is driven.
REQ-009 tx_data  out  8  outgoing byte.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  sink accepts; transfer = tx_valid & tx_ready on a rising edge.
REQ-012 resethist  out  1  one-cycle histogram clear pulse to the counter block.
REQ-013 busy  out  1  high from accepted start until frame done (plus clear hold).
REQ-014 done  out  1  one-cycle pulse when busy falls.

Function
REQ-015 Frame byte order: header 0xA5, then words 0..NWORDS-1 each MSB first, then checksum byte; 266 bytes at default.
REQ-016 Checksum = XOR of all 264 word bytes, header excluded, cleared at each accepted start.
REQ-017 FSM states IDLE, HDR, FETCH, LATCH, SEND, CSUM, CLR, HOLD; encoding free.
REQ-018 IDLE: start=1 -> HDR, busy=1, capture clear_after, word index=0, byte index=0; start ignored in all other states.
REQ-019 HDR: tx_valid=1, tx_data=0xA5; on transfer -> FETCH.
REQ-020 FETCH: rd_addr=word index for one cycle, tx_valid=0 -> LATCH.
REQ-021 LATCH: capture rd_data into 32-bit shift register -> SEND; rd_addr holds value.
REQ-022 SEND: tx_data = shift[31:24]; on transfer shift left 8, XOR byte into checksum, byte index+1; after 4th byte: word index = last -> CSUM, else word index+1 -> FETCH.
REQ-023 CSUM: tx_data=checksum; on transfer -> CLR if clear_after captured 1, else -> IDLE with done=1.
REQ-024 CLR: resethist=1 for exactly one cycle, load hold counter CLR_HOLD-1 -> HOLD.
REQ-025 HOLD: decrement each cycle; at 0 -> IDLE with done=1; busy stays 1 throughout.
REQ-026 tx_valid shall not depend combinationally on tx_ready; tx_data stable while tx_valid=1 and tx_ready=0.
REQ-027 tx_valid=0 in IDLE, FETCH, LATCH, CLR, HOLD; no bytes emitted outside a frame.
REQ-028 Minimum latency: start at edge N -> tx_valid=1 with 0xA5 from edge N+1.
REQ-029 With tx_ready tied 1, each word costs 6 cycles (FETCH, LATCH, 4 SEND); 1+66*6+1=398 cycles start-to-checksum accepted.
REQ-030 Word index counter 7 bits, byte index 2 bits wrapping 3->0; no overflow beyond NWORDS-1.
REQ-031 rd_data sampled only in LATCH; changes at other times have no effect.

Reset
REQ-032 resetn=0 forces IDLE asynchronously: tx_valid=0, tx_data=0, rd_addr=0, resethist=0, busy=0, done=0, checksum=0, counters=0.
REQ-033 Reset mid-frame aborts without a resethist pulse or done pulse; first frame after release starts with header.
REQ-034 Release of resetn shall be synchronised so no state advances on the release edge.

Verification
REQ-035 Words i = 0x01020304*(i+1) mod 2^32, tx_ready=1, clear_after=0 -> 266 bytes, header 0xA5, word 0 = 01 02 03 04, correct XOR, done at cycle 398, no resethist.
REQ-036 Same frame, tx_ready random 30% duty -> identical byte sequence, tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-037 clear_after=1 -> exactly one resethist pulse one cycle after checksum accepted, busy high 70 further cycles, then done.
REQ-038 start pulsed during SEND and HOLD -> ignored, single frame only.
REQ-039 resetn asserted at byte 100 -> all outputs 0 immediately, no resethist; new start yields full correct frame.
REQ-040 All rd_data = 0xFFFFFFFF -> checksum 0x00 (264 bytes of 0xFF XOR to 0).
